// File: rtl/control_ventana_lecturas.sv
// ============================================================================
// Module  : control_ventana_lecturas
// Purpose : Register-programmed sequencer that emits a window of memory reads.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module control_ventana_lecturas #(
  parameter int BITS_BUS_DATOS_INSTR     = 24,
  parameter int BITS_BUS_DIRECCION_INSTR = 8,
  parameter int BITS_DIRECCION_MEM       = 10,
  parameter int BITS_BUFFERS             = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [BITS_BUS_DIRECCION_INSTR-1:0] direccion_registros,
  input  logic [BITS_BUS_DATOS_INSTR-1:0]     datos_registros,
  input  logic                                habilitacion_registros,
  input  logic                                lectura_registros,
  output logic [BITS_BUS_DATOS_INSTR-1:0]     datos_lectura,
  output logic [BITS_DIRECCION_MEM-1:0]       mem_direccion,
  output logic                                mem_solicitud,
  input  logic                                mem_listo,
  output logic                                ocupado,
  output logic                                fin,
  output logic [BITS_DIRECCION_MEM-1:0]       direccion_mem_inicio_imagen,
  output logic [BITS_BUS_DATOS_INSTR-1:0]     cantidad_lecturas_mem,
  output logic [BITS_BUFFERS-1:0]             cantidad_buffers_internos
);

  localparam logic [2:0] DIR_INICIO   = 3'd0;
  localparam logic [2:0] DIR_CANTIDAD = 3'd1;
  localparam logic [2:0] DIR_BUFFERS  = 3'd2;
  localparam logic [2:0] DIR_CONTROL  = 3'd3;
  localparam logic [2:0] DIR_ESTADO   = 3'd4;
  localparam logic [2:0] DIR_LECTURAS = 3'd5;

  localparam logic [BITS_DIRECCION_MEM-1:0]   UNO_MEM   = 1;
  localparam logic [BITS_BUS_DATOS_INSTR-1:0] UNO_DATOS = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMITIR = 2'd1,
    FIN    = 2'd2
  } estado_t;

  estado_t                         estado_q, estado_d;
  logic [BITS_DIRECCION_MEM-1:0]   inicio_q, inicio_d;
  logic [BITS_BUS_DATOS_INSTR-1:0] cantidad_q, cantidad_d;
  logic [BITS_BUFFERS-1:0]         buffers_q, buffers_d;
  logic [BITS_DIRECCION_MEM-1:0]   direccion_q, direccion_d;
  logic [BITS_BUS_DATOS_INSTR-1:0] lecturas_q, lecturas_d;
  logic                            hecho_q, hecho_d;
  logic                            error_q, error_d;
  logic                            abortado_q, abortado_d;
  logic [BITS_BUS_DATOS_INSTR-1:0] datos_lectura_q, datos_lectura_d;

  logic [2:0]                      w_sel;
  logic                            w_ocupado;
  logic                            w_escribe_cfg;
  logic                            w_arranque;
  logic                            w_aborto;
  logic                            w_config_valida;
  logic [BITS_BUS_DATOS_INSTR-1:0] w_lecturas_inc;
  logic [BITS_BUS_DATOS_INSTR-1:0] w_mux_lectura;
  logic                            w_unused_dir;

  assign w_sel           = direccion_registros[2:0];
  assign w_unused_dir    = ^direccion_registros[BITS_BUS_DIRECCION_INSTR-1:3];
  assign w_ocupado       = (estado_q != IDLE);
  assign w_escribe_cfg   = habilitacion_registros && !w_ocupado;
  assign w_arranque      = habilitacion_registros && (w_sel == DIR_CONTROL) && datos_registros[0];
  assign w_aborto        = habilitacion_registros && (w_sel == DIR_CONTROL) && datos_registros[1];
  assign w_config_valida = (cantidad_q != '0) && (buffers_q != '0);
  assign w_lecturas_inc  = lecturas_q + UNO_DATOS;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q        <= IDLE;
      inicio_q        <= '0;
      cantidad_q      <= '0;
      buffers_q       <= '0;
      direccion_q     <= '0;
      lecturas_q      <= '0;
      hecho_q         <= 1'b0;
      error_q         <= 1'b0;
      abortado_q      <= 1'b0;
      datos_lectura_q <= '0;
    end else begin
      estado_q        <= estado_d;
      inicio_q        <= inicio_d;
      cantidad_q      <= cantidad_d;
      buffers_q       <= buffers_d;
      direccion_q     <= direccion_d;
      lecturas_q      <= lecturas_d;
      hecho_q         <= hecho_d;
      error_q         <= error_d;
      abortado_q      <= abortado_d;
      datos_lectura_q <= datos_lectura_d;
    end
  end

  // Sticky-bit clears are applied first so any set event later in this block wins.
  always_comb begin
    estado_d    = estado_q;
    inicio_d    = inicio_q;
    cantidad_d  = cantidad_q;
    buffers_d   = buffers_q;
    direccion_d = direccion_q;
    lecturas_d  = lecturas_q;
    hecho_d     = hecho_q;
    error_d     = error_q;
    abortado_d  = abortado_q;

    if (w_escribe_cfg) begin
      case (w_sel)
        DIR_INICIO:   inicio_d   = datos_registros[BITS_DIRECCION_MEM-1:0];
        DIR_CANTIDAD: cantidad_d = datos_registros;
        DIR_BUFFERS:  buffers_d  = datos_registros[BITS_BUFFERS-1:0];
        default:      ;
      endcase
    end

    if (habilitacion_registros && (w_sel == DIR_ESTADO)) begin
      if (datos_registros[1]) hecho_d    = 1'b0;
      if (datos_registros[2]) error_d    = 1'b0;
      if (datos_registros[3]) abortado_d = 1'b0;
    end

    case (estado_q)
      IDLE: begin
        if (w_arranque) begin
          if (w_config_valida) begin
            estado_d    = EMITIR;
            direccion_d = inicio_q;
            lecturas_d  = '0;
            hecho_d     = 1'b0;
            abortado_d  = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      EMITIR: begin
        if (mem_listo) begin
          direccion_d = direccion_q + UNO_MEM;
          lecturas_d  = w_lecturas_inc;
        end
        if (w_aborto) begin
          estado_d   = IDLE;
          abortado_d = 1'b1;
        end else if (mem_listo && (w_lecturas_inc == cantidad_q)) begin
          estado_d = FIN;
        end
      end
      FIN: begin
        hecho_d  = 1'b1;
        estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  always_comb begin
    w_mux_lectura = '0;
    case (w_sel)
      DIR_INICIO:   w_mux_lectura[BITS_DIRECCION_MEM-1:0] = inicio_q;
      DIR_CANTIDAD: w_mux_lectura = cantidad_q;
      DIR_BUFFERS:  w_mux_lectura[BITS_BUFFERS-1:0] = buffers_q;
      DIR_ESTADO:   w_mux_lectura[3:0] = {abortado_q, error_q, hecho_q, w_ocupado};
      DIR_LECTURAS: w_mux_lectura = lecturas_q;
      default:      w_mux_lectura = '0;
    endcase
    datos_lectura_d = lectura_registros ? w_mux_lectura : datos_lectura_q;
  end

  assign datos_lectura               = datos_lectura_q;
  assign mem_direccion               = direccion_q;
  assign mem_solicitud               = (estado_q == EMITIR);
  assign ocupado                     = w_ocupado;
  assign fin                         = (estado_q == FIN);
  assign direccion_mem_inicio_imagen = inicio_q;
  assign cantidad_lecturas_mem       = cantidad_q;
  assign cantidad_buffers_internos   = buffers_q;

endmodule

`default_nettype wire

// File: tb/tb_control_ventana_lecturas.sv
// ============================================================================
// Module  : tb_control_ventana_lecturas
// Purpose : Directed + randomized checks of the read-window sequencer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_control_ventana_lecturas;

  localparam int D = 24;
  localparam int A = 8;
  localparam int M = 10;
  localparam int B = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [A-1:0] direccion_registros = '0;
  logic [D-1:0] datos_registros = '0;
  logic         habilitacion_registros = 1'b0;
  logic         lectura_registros = 1'b0;
  logic [D-1:0] datos_lectura;
  logic [M-1:0] mem_direccion;
  logic         mem_solicitud;
  logic         mem_listo = 1'b0;
  logic         ocupado;
  logic         fin;
  logic [M-1:0] direccion_mem_inicio_imagen;
  logic [D-1:0] cantidad_lecturas_mem;
  logic [B-1:0] cantidad_buffers_internos;

  int           total = 0;
  int           bad = 0;
  logic [D-1:0] v;

  control_ventana_lecturas #(
    .BITS_BUS_DATOS_INSTR    (D),
    .BITS_BUS_DIRECCION_INSTR(A),
    .BITS_DIRECCION_MEM      (M),
    .BITS_BUFFERS            (B)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .direccion_registros        (direccion_registros),
    .datos_registros            (datos_registros),
    .habilitacion_registros     (habilitacion_registros),
    .lectura_registros          (lectura_registros),
    .datos_lectura              (datos_lectura),
    .mem_direccion              (mem_direccion),
    .mem_solicitud              (mem_solicitud),
    .mem_listo                  (mem_listo),
    .ocupado                    (ocupado),
    .fin                        (fin),
    .direccion_mem_inicio_imagen(direccion_mem_inicio_imagen),
    .cantidad_lecturas_mem      (cantidad_lecturas_mem),
    .cantidad_buffers_internos  (cantidad_buffers_internos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [D-1:0] d);
    direccion_registros    = {5'b0, a};
    datos_registros        = d;
    habilitacion_registros = 1'b1;
    @(posedge clk); #1;
    habilitacion_registros = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [D-1:0] d);
    direccion_registros = {5'b0, a};
    lectura_registros   = 1'b1;
    @(posedge clk); #1;
    lectura_registros   = 1'b0;
    d = datos_lectura;
  endtask

  // Reference: the k-th issued address is (start + k) mod 2^M; the run ends
  // on acceptance number cnt unless an abort write lands first (abort wins).
  task automatic run(input int start, input int cnt, input logic [31:0] pat,
                     input bit use_rand, input int abort_at, input int side_op);
    int acc = 0;
    int cyc = 0;
    bit aborted = 0;
    bit listo_now;
    bit ab_now;
    logic [D-1:0] r;
    wr(3'd0, D'(start));
    wr(3'd1, D'(cnt));
    wr(3'd2, D'(2));
    wr(3'd4, D'(32'hE));
    check("cfg_start_out", 32'(direccion_mem_inicio_imagen), start % 1024);
    check("cfg_count_out", 32'(cantidad_lecturas_mem), cnt);
    wr(3'd3, D'(1));
    check("busy_after_start", 32'(ocupado), 1);
    while (acc < cnt && !aborted && cyc < 200) begin
      check("req_high", 32'(mem_solicitud), 1);
      check("addr", 32'(mem_direccion), (start + acc) % 1024);
      check("no_fin_mid", 32'(fin), 0);
      listo_now = use_rand ? 1'($urandom_range(0, 1)) : pat[cyc % 32];
      mem_listo = listo_now;
      ab_now = (abort_at >= 0) && (acc >= abort_at);
      if (ab_now) begin
        direccion_registros = 8'd3; datos_registros = D'(2); habilitacion_registros = 1'b1;
      end else if (side_op == 1 && cyc == 1) begin
        direccion_registros = 8'd1; datos_registros = D'(32'h55); habilitacion_registros = 1'b1;
      end else if (side_op == 2 && cyc == 1) begin
        direccion_registros = 8'd3; datos_registros = D'(1); habilitacion_registros = 1'b1;
      end
      @(posedge clk); #1;
      habilitacion_registros = 1'b0;
      mem_listo = 1'b0;
      acc += int'(listo_now);
      cyc++;
      if (ab_now) aborted = 1;
    end
    if (aborted) begin
      check("abort_idle", 32'(ocupado), 0);
      check("abort_no_fin", 32'(fin), 0);
      check("abort_no_req", 32'(mem_solicitud), 0);
      rd(3'd4, r);
      check("abort_status", 32'(r), 32'h8);
    end else begin
      check("accepted_all", acc, cnt);
      check("fin_pulse", 32'(fin), 1);
      check("fin_no_req", 32'(mem_solicitud), 0);
      @(posedge clk); #1;
      check("fin_one_cycle", 32'(fin), 0);
      check("idle_after_fin", 32'(ocupado), 0);
      rd(3'd4, r);
      check("done_status", 32'(r), 32'h2);
    end
    rd(3'd5, r);
    check("reads_reg", 32'(r), acc);
    if (side_op == 1) check("count_protected", 32'(cantidad_lecturas_mem), cnt);
  endtask

  initial begin
    #12;
    check("rst_req", 32'(mem_solicitud), 0);
    check("rst_busy", 32'(ocupado), 0);
    check("rst_addr", 32'(mem_direccion), 0);
    check("rst_rdata", 32'(datos_lectura), 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      rd(3'(i), v);
      check("rst_reg", 32'(v), 0);
    end

    // Unused addresses ignore writes and read as zero
    wr(3'd6, D'(32'hABC));
    rd(3'd6, v);
    check("reg6_zero", 32'(v), 0);
    wr(3'd1, D'(32'h123456));
    rd(3'd1, v);
    check("count_rw", 32'(v), 32'h123456);
    wr(3'd7, D'(32'h77));
    rd(3'd7, v);
    check("reg7_zero", 32'(v), 0);
    @(posedge clk); #1;
    check("rdata_holds", 32'(datos_lectura), 0);

    // Invalid starts: count 0, then buffers 0
    wr(3'd1, D'(0));
    wr(3'd2, D'(2));
    wr(3'd3, D'(1));
    for (int i = 0; i < 3; i++) begin
      check("inv_no_req", 32'(mem_solicitud), 0);
      @(posedge clk); #1;
    end
    rd(3'd4, v);
    check("inv_status_cnt0", 32'(v), 32'h4);
    wr(3'd4, D'(32'h4));
    rd(3'd4, v);
    check("err_cleared", 32'(v), 0);
    wr(3'd1, D'(5));
    wr(3'd2, D'(0));
    wr(3'd3, D'(1));
    check("inv_buf0_idle", 32'(ocupado), 0);
    rd(3'd4, v);
    check("inv_status_buf0", 32'(v), 32'h4);
    wr(3'd4, D'(32'h4));

    // Start+abort together in idle: start taken, abort ignored
    wr(3'd2, D'(1));
    wr(3'd3, D'(3));
    check("start_abort_idle", 32'(ocupado), 1);
    wr(3'd3, D'(2));
    check("abort_stops", 32'(ocupado), 0);

    run(32'h010, 4, 32'hFFFF_FFFF, 0, -1, 0);
    run(32'h3FE, 4, 32'hFFFF_FFFF, 0, -1, 0);
    run(32'h005, 3, 32'h0000_0029, 0, -1, 0);
    run(32'h020, 8, 32'h0, 1, 3, 0);
    run(32'h040, 6, 32'h0, 1, -1, 1);
    run(32'h080, 5, 32'h0, 1, -1, 2);
    for (int i = 0; i < 4; i++) begin
      run(int'($urandom_range(0, 1023)), int'($urandom_range(1, 10)), 32'h0, 1, -1, 0);
    end

    // Asynchronous reset in the middle of a transfer
    wr(3'd0, D'(32'h100));
    wr(3'd1, D'(20));
    wr(3'd2, D'(1));
    wr(3'd3, D'(1));
    mem_listo = 1'b1;
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_req", 32'(mem_solicitud), 0);
    check("arst_busy", 32'(ocupado), 0);
    check("arst_fin", 32'(fin), 0);
    check("arst_addr", 32'(mem_direccion), 0);
    check("arst_rdata", 32'(datos_lectura), 0);
    check("arst_cfg_start", 32'(direccion_mem_inicio_imagen), 0);
    check("arst_cfg_count", 32'(cantidad_lecturas_mem), 0);
    check("arst_cfg_buf", 32'(cantidad_buffers_internos), 0);
    mem_listo = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    rd(3'd4, v);
    check("arst_status", 32'(v), 0);
    rd(3'd5, v);
    check("arst_reads", 32'(v), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
